l2_rd_arbiter: RTL and testbench
================================

Name: l2_rd_arbiter

Overview:
Two-master AXI read-channel arbiter placed between the L1 caches and the single L2 cache read port. It shares the L2 AR/R channels between the IL1 refill port and the DL1 refill port. Grants are round-robin, one burst outstanding at a time, and R beats are routed to the owner until RLAST. It also provides a hold input so fence sequencing can drain the port, and a sticky burst-length checker.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, R data width
LEN_W, 8, ARLEN width (AXI4)

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-high reset
IL1_ARADDR/IL1_ARLEN/IL1_ARBURST  input  ADDR_W/LEN_W/2  IL1 read request fields
IL1_ARVALID  input  1  IL1 request valid
IL1_ARREADY  output  1  IL1 request accepted
IL1_RDATA/IL1_RRESP  output  DATA_W/2  IL1 read data, response
IL1_RLAST/IL1_RVALID  output  1/1  IL1 last beat, beat valid
IL1_RREADY  input  1  IL1 beat ready
DL1_AR*/DL1_R*  same set as IL1_*  same widths  DL1 refill port
L2C_ARADDR/L2C_ARLEN/L2C_ARBURST  output  ADDR_W/LEN_W/2  registered request to L2
L2C_ARVALID  output  1  request valid to L2
L2C_ARREADY  input  1  L2 request accepted
L2C_RDATA/L2C_RRESP/L2C_RLAST/L2C_RVALID  input  DATA_W/2/1/1  L2 read data channel
L2C_RREADY  output  1  beat ready to L2
arb_hold  input  1  block new grants (fence drain)
arb_busy  output  1  state != IDLE
arb_owner  output  1  current/last owner, 0=IL1, 1=DL1
len_err  output  1  sticky burst-length mismatch

Behaviour:
- Reset (async, RST=1): state=IDLE, rr_ptr=0 (IL1 preferred), owner=0, beat_cnt=0, len_err=0.
- Reset outputs: all *_ARREADY, L2C_ARVALID, IL1/DL1_RVALID, L2C_RREADY = 0; L2C_AR* fields = 0.
- Reset mid-burst abandons the transfer; L2C_ARVALID and RVALIDs drop in the same cycle RST asserts.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If arb_hold=0 and any upstream ARVALID=1, pick a winner. A single requester always wins. With both valid, rr_ptr decides (0→IL1, 1→DL1).
  - The winner's ARREADY is driven combinationally high in the same cycle, and the loser's ARREADY stays 0.
  - On that handshake: latch ADDR/LEN/BURST into the L2C_AR* registers, owner←winner, beat_cnt←0, go to ADDR.
  - With arb_hold=1 no ARREADY is issued and the state stays IDLE.
- ADDR:
  - L2C_ARVALID=1, registered; first asserted the cycle after the upstream handshake (1-cycle latency).
  - Fields are stable until L2C_ARREADY=1; then go to DATA with L2C_ARVALID=0 next cycle.
  - Upstream ARREADY is 0 in ADDR and DATA.
- DATA:
  - The R channel is combinational pass-through to the owner: owner RVALID=L2C_RVALID, with RDATA/RRESP/RLAST passed through; L2C_RREADY=owner RREADY.
  - Non-owner RVALID=0. Non-owner RDATA/RRESP/RLAST=0.
  - On each beat handshake (L2C_RVALID & L2C_RREADY), beat_cnt increments, wrapping at 2^LEN_W.
  - On a handshake with RLAST=1: go to IDLE, rr_ptr←~owner.
  - L2C_RVALID in ADDR or IDLE is ignored (L2C_RREADY=0).
- Length check: len_err is set sticky when
  - RLAST=1 on a handshake where beat_cnt != latched ARLEN, or
  - RLAST=0 on a handshake where beat_cnt == ARLEN.
  len_err clears only on reset. The burst always terminates on RLAST, never on the count.
- arb_hold asserted in ADDR/DATA does not abort; the burst completes, then the arbiter stays in IDLE.
- arb_busy=1 in ADDR and DATA.
- arb_owner holds its last value in IDLE.
- Throughput: minimum 3 cycles per single-beat burst (IDLE accept, ADDR, DATA beat). The next grant is possible in the cycle after the RLAST handshake.

Decomposition:
- Package l2_arb_pkg: state enum (IDLE, ADDR, DATA), owner encoding (OWN_IL1=0, OWN_DL1=1), AXI burst constants (INCR=2'b01, WRAP=2'b10), default widths.
- One sub-module, rr_arb2: 2-way round-robin picker, combinational grant from {req1,req0} and rr_ptr.
- State, registers and R muxing stay in the top module.

Test Plan:
- IL1 only, ARADDR=0x8000_0000, ARLEN=7, RR beats with RREADY=1 → IL1_ARREADY same cycle, L2C_ARVALID next cycle with ADDR=0x8000_0000/LEN=7, 8 beats to IL1, DL1_RVALID=0 throughout, len_err=0, rr_ptr=1 afterwards.
- Both ARVALID in the same cycle after reset → IL1 granted first; DL1 is granted in the cycle after IL1's RLAST. Repeat the pair → grants alternate IL1, DL1, IL1, DL1.
- L2C_ARREADY held 0 for 5 cycles → L2C_ARVALID stays 1 with stable fields; no upstream ARREADY during the wait.
- Owner RREADY toggled 1,0,1,0 across a 4-beat DL1 burst → L2C_RREADY mirrors it, beat_cnt advances only on handshakes, completion after 4 handshakes.
- ARLEN=3 but L2 asserts RLAST on beat 2 → len_err=1 and stays 1 across a following correct burst; return to IDLE after that RLAST.
- arb_hold=1 raised mid-burst with DL1 ARVALID pending → current burst completes, no DL1_ARREADY while hold=1. Hold drops → DL1 granted the same cycle. Separately, RST pulsed in DATA → all valids/readys 0 immediately, arb_busy=0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 read-channel arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_IL1 = 1'b0;
    localparam logic OWN_DL1 = 1'b1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie is
// broken by the pointer (0 -> requester 0, 1 -> requester 1).
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic [1:0] o_gnt
);

    // One-hot grant from the request pair and the tie-break pointer
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = i_rr_ptr ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/l2_rd_arbiter.sv
// Shares the single L2 AR/R read port between the IL1 and DL1 refill ports.
// One burst is outstanding at a time; R beats go to the owner until RLAST.
module l2_rd_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] IL1_ARADDR,
    input  logic [LEN_W-1:0]  IL1_ARLEN,
    input  logic [1:0]        IL1_ARBURST,
    input  logic              IL1_ARVALID,
    output logic              IL1_ARREADY,
    output logic [DATA_W-1:0] IL1_RDATA,
    output logic [1:0]        IL1_RRESP,
    output logic              IL1_RLAST,
    output logic              IL1_RVALID,
    input  logic              IL1_RREADY,
    input  logic [ADDR_W-1:0] DL1_ARADDR,
    input  logic [LEN_W-1:0]  DL1_ARLEN,
    input  logic [1:0]        DL1_ARBURST,
    input  logic              DL1_ARVALID,
    output logic              DL1_ARREADY,
    output logic [DATA_W-1:0] DL1_RDATA,
    output logic [1:0]        DL1_RRESP,
    output logic              DL1_RLAST,
    output logic              DL1_RVALID,
    input  logic              DL1_RREADY,
    output logic [ADDR_W-1:0] L2C_ARADDR,
    output logic [LEN_W-1:0]  L2C_ARLEN,
    output logic [1:0]        L2C_ARBURST,
    output logic              L2C_ARVALID,
    input  logic              L2C_ARREADY,
    input  logic [DATA_W-1:0] L2C_RDATA,
    input  logic [1:0]        L2C_RRESP,
    input  logic              L2C_RLAST,
    input  logic              L2C_RVALID,
    output logic              L2C_RREADY,
    input  logic              arb_hold,
    output logic              arb_busy,
    output logic              arb_owner,
    output logic              len_err
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_rr_ptr;
    logic              r_owner;
    logic              r_len_err;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [ADDR_W-1:0] r_araddr;
    logic [LEN_W-1:0]  r_arlen;
    logic [1:0]        r_arburst;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_beat;
    logic              w_len_bad;

    rr_arb2 u_rr_arb2 (
        .i_req    ({DL1_ARVALID, IL1_ARVALID}),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus AR handshakes and the owner's R ready
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        IL1_ARREADY = 1'b0;
        DL1_ARREADY = 1'b0;
        L2C_ARVALID = 1'b0;
        L2C_RREADY  = 1'b0;
        case (r_state)
            IDLE: begin
                // RST gating keeps ARREADY low while reset is held
                if (!arb_hold && !RST && (w_gnt != 2'b00)) begin
                    w_accept    = 1'b1;
                    IL1_ARREADY = w_gnt[0];
                    DL1_ARREADY = w_gnt[1];
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                L2C_ARVALID = 1'b1;
                if (L2C_ARREADY) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                L2C_RREADY = (r_owner == OWN_DL1) ? DL1_RREADY : IL1_RREADY;
                w_beat     = L2C_RVALID & L2C_RREADY;
                if (w_beat && L2C_RLAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // R channel pass-through to the owner; everything else is held at zero
    always_comb begin
        IL1_RVALID = 1'b0;
        IL1_RDATA  = '0;
        IL1_RRESP  = 2'b00;
        IL1_RLAST  = 1'b0;
        DL1_RVALID = 1'b0;
        DL1_RDATA  = '0;
        DL1_RRESP  = 2'b00;
        DL1_RLAST  = 1'b0;
        if (r_state == DATA) begin
            if (r_owner == OWN_DL1) begin
                DL1_RVALID = L2C_RVALID;
                DL1_RDATA  = L2C_RDATA;
                DL1_RRESP  = L2C_RRESP;
                DL1_RLAST  = L2C_RLAST;
            end else begin
                IL1_RVALID = L2C_RVALID;
                IL1_RDATA  = L2C_RDATA;
                IL1_RRESP  = L2C_RRESP;
                IL1_RLAST  = L2C_RLAST;
            end
        end
    end

    // RLAST must land exactly on beat ARLEN; either early or late is an error
    assign w_len_bad = w_beat && (L2C_RLAST ? (r_beat_cnt != r_arlen)
                                            : (r_beat_cnt == r_arlen));

    // Request latch, ownership, tie-break pointer, beat count and sticky error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arburst  <= 2'b00;
            r_owner    <= OWN_IL1;
            r_rr_ptr   <= OWN_IL1;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr   <= w_gnt[1] ? DL1_ARADDR  : IL1_ARADDR;
                r_arlen    <= w_gnt[1] ? DL1_ARLEN   : IL1_ARLEN;
                r_arburst  <= w_gnt[1] ? DL1_ARBURST : IL1_ARBURST;
                r_owner    <= w_gnt[1] ? OWN_DL1     : OWN_IL1;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_beat && L2C_RLAST) begin
                r_rr_ptr <= ~r_owner;
            end
            if (w_len_bad) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign L2C_ARADDR  = r_araddr;
    assign L2C_ARLEN   = r_arlen;
    assign L2C_ARBURST = r_arburst;
    assign arb_busy    = (r_state != IDLE);
    assign arb_owner   = r_owner;
    assign len_err     = r_len_err;

endmodule

// File: tb/tb_l2_rd_arbiter.sv
// Directed bench for l2_rd_arbiter: a table of whole bursts followed by
// hand-written sequences for stalls, back-pressure, hold, length errors
// and reset in the middle of a transfer.
module tb_l2_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [ADDR_W-1:0] IL1_ARADDR, DL1_ARADDR, L2C_ARADDR;
    logic [LEN_W-1:0]  IL1_ARLEN, DL1_ARLEN, L2C_ARLEN;
    logic [1:0]        IL1_ARBURST, DL1_ARBURST, L2C_ARBURST;
    logic              IL1_ARVALID, IL1_ARREADY, DL1_ARVALID, DL1_ARREADY;
    logic [DATA_W-1:0] IL1_RDATA, DL1_RDATA, L2C_RDATA;
    logic [1:0]        IL1_RRESP, DL1_RRESP, L2C_RRESP;
    logic              IL1_RLAST, IL1_RVALID, IL1_RREADY;
    logic              DL1_RLAST, DL1_RVALID, DL1_RREADY;
    logic              L2C_ARVALID, L2C_ARREADY;
    logic              L2C_RLAST, L2C_RVALID, L2C_RREADY;
    logic              arb_hold, arb_busy, arb_owner, len_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        il1_v;
        logic        dl1_v;
        logic [31:0] addr;
        logic [7:0]  len;
        int          rlast_beat;
        logic        exp_owner;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    always #5 CLK = ~CLK;

    l2_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST),
        .IL1_ARADDR(IL1_ARADDR), .IL1_ARLEN(IL1_ARLEN), .IL1_ARBURST(IL1_ARBURST),
        .IL1_ARVALID(IL1_ARVALID), .IL1_ARREADY(IL1_ARREADY),
        .IL1_RDATA(IL1_RDATA), .IL1_RRESP(IL1_RRESP), .IL1_RLAST(IL1_RLAST),
        .IL1_RVALID(IL1_RVALID), .IL1_RREADY(IL1_RREADY),
        .DL1_ARADDR(DL1_ARADDR), .DL1_ARLEN(DL1_ARLEN), .DL1_ARBURST(DL1_ARBURST),
        .DL1_ARVALID(DL1_ARVALID), .DL1_ARREADY(DL1_ARREADY),
        .DL1_RDATA(DL1_RDATA), .DL1_RRESP(DL1_RRESP), .DL1_RLAST(DL1_RLAST),
        .DL1_RVALID(DL1_RVALID), .DL1_RREADY(DL1_RREADY),
        .L2C_ARADDR(L2C_ARADDR), .L2C_ARLEN(L2C_ARLEN), .L2C_ARBURST(L2C_ARBURST),
        .L2C_ARVALID(L2C_ARVALID), .L2C_ARREADY(L2C_ARREADY),
        .L2C_RDATA(L2C_RDATA), .L2C_RRESP(L2C_RRESP), .L2C_RLAST(L2C_RLAST),
        .L2C_RVALID(L2C_RVALID), .L2C_RREADY(L2C_RREADY),
        .arb_hold(arb_hold), .arb_busy(arb_busy), .arb_owner(arb_owner),
        .len_err(len_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        IL1_ARADDR = '0; IL1_ARLEN = '0; IL1_ARBURST = 2'b01; IL1_ARVALID = 1'b0;
        DL1_ARADDR = '0; DL1_ARLEN = '0; DL1_ARBURST = 2'b01; DL1_ARVALID = 1'b0;
        IL1_RREADY = 1'b1; DL1_RREADY = 1'b1;
        L2C_ARREADY = 1'b0; L2C_RDATA = '0; L2C_RRESP = 2'b00;
        L2C_RLAST = 1'b0; L2C_RVALID = 1'b0; arb_hold = 1'b0;
    endtask

    // Asserts reset with requests and R data present to show nothing leaks
    task automatic do_reset(input string tag);
        IL1_ARVALID = 1'b1; DL1_ARVALID = 1'b1; L2C_RVALID = 1'b1;
        RST = 1'b1;
        #1;
        check({tag, "_il1_arready"}, IL1_ARREADY, 0);
        check({tag, "_dl1_arready"}, DL1_ARREADY, 0);
        check({tag, "_l2_arvalid"},  L2C_ARVALID, 0);
        check({tag, "_l2_araddr"},   L2C_ARADDR, 0);
        check({tag, "_l2_arlen"},    L2C_ARLEN, 0);
        check({tag, "_rvalids"},     {IL1_RVALID, DL1_RVALID}, 0);
        check({tag, "_l2_rready"},   L2C_RREADY, 0);
        check({tag, "_busy"},        arb_busy, 0);
        check({tag, "_owner"},       arb_owner, 0);
        check({tag, "_len_err"},     len_err, 0);
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic addr_phase();
        L2C_ARREADY = 1'b1;
        @(negedge CLK);
        L2C_ARREADY = 1'b0;
    endtask

    task automatic beat(input logic last);
        L2C_RVALID = 1'b1;
        L2C_RLAST  = last;
        @(negedge CLK);
        L2C_RVALID = 1'b0;
        L2C_RLAST  = 1'b0;
    endtask

    // Whole burst from IDLE; the DL1 address is the IL1 address plus 0x100
    task automatic run_burst(input string tag, input logic il1_v, input logic dl1_v,
                             input logic [31:0] addr, input logic [7:0] len,
                             input int rlast_beat, input logic exp_owner, input logic exp_err);
        logic [63:0] pat;
        IL1_ARADDR = addr;          IL1_ARLEN = len; IL1_ARBURST = 2'b01;
        DL1_ARADDR = addr + 32'h100; DL1_ARLEN = len; DL1_ARBURST = 2'b10;
        IL1_ARVALID = il1_v; DL1_ARVALID = dl1_v;
        #1;
        check({tag, "_il1_arready"}, IL1_ARREADY, exp_owner == 1'b0);
        check({tag, "_dl1_arready"}, DL1_ARREADY, exp_owner == 1'b1);
        @(negedge CLK);
        IL1_ARVALID = 1'b0; DL1_ARVALID = 1'b0;
        #1;
        check({tag, "_l2_arvalid"},  L2C_ARVALID, 1);
        check({tag, "_l2_araddr"},   L2C_ARADDR, exp_owner ? addr + 32'h100 : addr);
        check({tag, "_l2_arlen"},    L2C_ARLEN, len);
        check({tag, "_l2_arburst"},  L2C_ARBURST, exp_owner ? 2'b10 : 2'b01);
        check({tag, "_owner"},       arb_owner, exp_owner);
        check({tag, "_busy"},        arb_busy, 1);
        addr_phase();
        #1;
        check({tag, "_l2_arvalid_off"}, L2C_ARVALID, 0);
        for (int b = 0; b <= rlast_beat; b++) begin
            pat = 64'hDA7A_0000_0000_0000 | 64'(b);
            L2C_RDATA = pat; L2C_RRESP = 2'(b); L2C_RLAST = (b == rlast_beat);
            L2C_RVALID = 1'b1;
            #1;
            check($sformatf("%s_b%0d_rvalid", tag, b), exp_owner ? DL1_RVALID : IL1_RVALID, 1);
            check($sformatf("%s_b%0d_rdata", tag, b),  exp_owner ? DL1_RDATA : IL1_RDATA, pat);
            check($sformatf("%s_b%0d_rlast", tag, b),  exp_owner ? DL1_RLAST : IL1_RLAST, b == rlast_beat);
            check($sformatf("%s_b%0d_other", tag, b),
                  exp_owner ? {IL1_RVALID, IL1_RDATA[7:0]} : {DL1_RVALID, DL1_RDATA[7:0]}, 0);
            @(negedge CLK);
        end
        L2C_RVALID = 1'b0; L2C_RLAST = 1'b0;
        #1;
        check({tag, "_busy_end"}, arb_busy, 0);
        check({tag, "_len_err"},  len_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hs;
        logic exp_rr;
        tbl[0] = '{1'b1, 1'b0, 32'h8000_0000, 8'd7, 7, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_1000, 8'd3, 3, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2000, 8'd0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_3000, 8'd1, 1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_4000, 8'd2, 2, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_5000, 8'd0, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_6000, 8'd3, 2, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_7000, 8'd1, 1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 32'h0000_8000, 8'd0, 0, 1'b1, 1'b1};

        idle_inputs();
        do_reset("rst0");
        for (int i = 0; i < 9; i++) begin
            run_burst($sformatf("v%0d", i), tbl[i].il1_v, tbl[i].dl1_v, tbl[i].addr,
                      tbl[i].len, tbl[i].rlast_beat, tbl[i].exp_owner, tbl[i].exp_err);
        end

        // Tie after reset: IL1 first, DL1 granted the cycle after IL1's RLAST
        do_reset("rst1");
        IL1_ARADDR = 32'hA000_0000; DL1_ARADDR = 32'hB000_0000;
        IL1_ARLEN = 8'd0; DL1_ARLEN = 8'd0;
        IL1_ARVALID = 1'b1; DL1_ARVALID = 1'b1;
        #1;
        check("pair_il1_arready", IL1_ARREADY, 1);
        check("pair_dl1_arready", DL1_ARREADY, 0);
        @(negedge CLK);
        IL1_ARVALID = 1'b0;
        #1;
        check("pair_dl1_wait_addr", DL1_ARREADY, 0);
        addr_phase();
        L2C_RVALID = 1'b1; L2C_RLAST = 1'b1;
        #1;
        check("pair_il1_rvalid", IL1_RVALID, 1);
        check("pair_dl1_wait_data", DL1_ARREADY, 0);
        @(negedge CLK);
        L2C_RVALID = 1'b0; L2C_RLAST = 1'b0;
        #1;
        check("pair_dl1_arready", DL1_ARREADY, 1);
        check("pair_busy_gap", arb_busy, 0);
        @(negedge CLK);
        DL1_ARVALID = 1'b0;
        #1;
        check("pair_dl1_addr", L2C_ARADDR, 32'hB000_0000);
        check("pair_dl1_owner", arb_owner, 1);
        addr_phase();
        beat(1'b1);
        #1;
        check("pair_dl1_done", arb_busy, 0);

        // L2 AR stall: fields held, no upstream ARREADY while waiting
        IL1_ARADDR = 32'h1234_5670; IL1_ARLEN = 8'd2; IL1_ARVALID = 1'b1;
        @(negedge CLK);
        IL1_ARADDR = 32'hFFFF_0000; DL1_ARVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stall%0d_arvalid", c), L2C_ARVALID, 1);
            check($sformatf("stall%0d_araddr", c),  L2C_ARADDR, 32'h1234_5670);
            check($sformatf("stall%0d_arreadys", c), {IL1_ARREADY, DL1_ARREADY}, 0);
            @(negedge CLK);
        end
        IL1_ARVALID = 1'b0; DL1_ARVALID = 1'b0;
        addr_phase();
        beat(1'b0); beat(1'b0); beat(1'b1);
        #1;
        check("stall_done", arb_busy, 0);
        check("stall_len_err", len_err, 0);

        // DL1 back-pressure: RREADY 1,0,1,0,... with RVALID held high
        DL1_ARADDR = 32'h0000_9000; DL1_ARLEN = 8'd3; DL1_ARVALID = 1'b1;
        @(negedge CLK);
        DL1_ARVALID = 1'b0;
        addr_phase();
        hs = 0;
        L2C_RVALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            DL1_RREADY = (i % 2 == 0);
            L2C_RLAST  = (hs == 3);
            #1;
            check($sformatf("bp%0d_l2_rready", i), L2C_RREADY, i % 2 == 0);
            check($sformatf("bp%0d_busy", i), arb_busy, 1);
            if (i % 2 == 0) hs++;
            @(negedge CLK);
        end
        L2C_RVALID = 1'b0; L2C_RLAST = 1'b0; DL1_RREADY = 1'b1;
        #1;
        check("bp_done", arb_busy, 0);
        check("bp_len_err", len_err, 0);

        // Hold raised mid-burst: burst finishes, DL1 waits until hold drops
        IL1_ARADDR = 32'h0000_A000; IL1_ARLEN = 8'd1; IL1_ARVALID = 1'b1;
        @(negedge CLK);
        IL1_ARVALID = 1'b0;
        addr_phase();
        arb_hold = 1'b1; DL1_ARADDR = 32'h0000_B000; DL1_ARLEN = 8'd0; DL1_ARVALID = 1'b1;
        beat(1'b0); beat(1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_dl1_arready", c), DL1_ARREADY, 0);
            check($sformatf("hold%0d_busy", c), arb_busy, 0);
            @(negedge CLK);
        end
        arb_hold = 1'b0;
        #1;
        check("hold_release_grant", DL1_ARREADY, 1);
        @(negedge CLK);
        DL1_ARVALID = 1'b0;
        addr_phase();
        beat(1'b1);

        // Late RLAST: beat ARLEN without RLAST flags the error, burst runs on
        IL1_ARADDR = 32'h0000_C000; IL1_ARLEN = 8'd1; IL1_ARVALID = 1'b1;
        exp_rr = 1'b0;
        @(negedge CLK);
        IL1_ARVALID = 1'b0;
        addr_phase();
        beat(1'b0);
        #1;
        check("late_err_before", len_err, 0);
        beat(1'b0);
        #1;
        check("late_err_set", len_err, 1);
        check("late_still_busy", arb_busy, 1);
        beat(1'b1);
        #1;
        check("late_done", arb_busy, 0);
        check("late_owner_held", arb_owner, exp_rr);
        run_burst("late_next", 1'b0, 1'b1, 32'h0000_D000, 8'd0, 0, 1'b1, 1'b1);

        // Reset while a beat is in flight
        IL1_ARADDR = 32'h0000_E000; IL1_ARLEN = 8'd3; IL1_ARVALID = 1'b1;
        @(negedge CLK);
        IL1_ARVALID = 1'b0;
        addr_phase();
        L2C_RVALID = 1'b1;
        #1;
        check("mid_rst_pre_rvalid", IL1_RVALID, 1);
        RST = 1'b1;
        #1;
        check("mid_rst_rvalid", IL1_RVALID, 0);
        check("mid_rst_l2_rready", L2C_RREADY, 0);
        check("mid_rst_arvalid", L2C_ARVALID, 0);
        check("mid_rst_busy", arb_busy, 0);
        check("mid_rst_len_err", len_err, 0);
        @(negedge CLK);
        L2C_RVALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post_rst_busy", arb_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
